vga_text_layer: RTL and testbench



---
 rtl/vga_pkg.sv | 32 +++
 rtl/vga_timing_gen.sv | 49 ++++
 rtl/vga_text_layer.sv | 216 +++++++++++++++++++++
 tb/tb_vga_text_layer.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared types and timing helpers for the VGA text layer.
package vga_pkg;

  typedef struct packed {
    logic [15:0] res_h;
    logic [15:0] h_fp;
    logic [15:0] h_sync;
    logic [15:0] h_bp;
    logic [15:0] res_v;
    logic [15:0] v_fp;
    logic [15:0] v_sync;
    logic [15:0] v_bp;
  } vga_timing_t;

  localparam int CELL_COLOR_W = 3;

  typedef struct packed {
    logic                    blink;
    logic [CELL_COLOR_W-1:0] bg;
    logic [CELL_COLOR_W-1:0] fg;
    logic [7:0]              ch;
  } vga_cell_t;

  function automatic logic [15:0] h_total(vga_timing_t t);
    return t.res_h + t.h_fp + t.h_sync + t.h_bp;
  endfunction

  function automatic logic [15:0] v_total(vga_timing_t t);
    return t.res_v + t.v_fp + t.v_sync + t.v_bp;
  endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// Free-running h/v raster counters with raw (unpipelined) sync levels.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter vga_timing_t TIMING = '{16'd640, 16'd16, 16'd96, 16'd48,
                                   16'd480, 16'd10, 16'd2, 16'd33},
  parameter logic SYNC_POL = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  output logic [15:0] h,
  output logic [15:0] v,
  output logic        hsync,
  output logic        vsync
);

  localparam logic [15:0] H_LAST   = h_total(TIMING) - 16'd1;
  localparam logic [15:0] V_LAST   = v_total(TIMING) - 16'd1;
  localparam logic [15:0] HS_START = TIMING.res_h + TIMING.h_fp;
  localparam logic [15:0] HS_END   = HS_START + TIMING.h_sync;
  localparam logic [15:0] VS_START = TIMING.res_v + TIMING.v_fp;
  localparam logic [15:0] VS_END   = VS_START + TIMING.v_sync;

  logic [15:0] h_r;
  logic [15:0] v_r;

  // raster position, v steps on every h wrap
  always_ff @(posedge clk) begin
    if (reset) begin
      h_r <= 16'd0;
      v_r <= 16'd0;
    end else if (h_r == H_LAST) begin
      h_r <= 16'd0;
      v_r <= (v_r == V_LAST) ? 16'd0 : v_r + 16'd1;
    end else begin
      h_r <= h_r + 16'd1;
    end
  end

  // raw sync levels for the current counter value
  always_comb begin
    hsync = ((h_r >= HS_START) && (h_r < HS_END)) ? SYNC_POL : ~SYNC_POL;
    vsync = ((v_r >= VS_START) && (v_r < VS_END)) ? SYNC_POL : ~SYNC_POL;
  end

  assign h = h_r;
  assign v = v_r;

endmodule

// File: rtl/vga_text_layer.sv
// Character-cell text overlay: cell counters, text-RAM/font-ROM fetch and
// a 4-clock pixel pipeline aligned with HSYNC/VSYNC/frame_start.
module vga_text_layer
  import vga_pkg::*;
#(
  parameter int   RES_H    = 640,
  parameter int   RES_V    = 480,
  parameter int   H_FP     = 16,
  parameter int   H_SYNC   = 96,
  parameter int   H_BP     = 48,
  parameter int   V_FP     = 10,
  parameter int   V_SYNC   = 2,
  parameter int   V_BP     = 33,
  parameter int   FONT_W   = 8,
  parameter int   FONT_H   = 8,
  parameter int   COLOR_W  = 3,
  parameter logic SYNC_POL = 1'b0,
  parameter int   COLS     = 80
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [2:0]                      scale_x,
  input  logic [2:0]                      scale_y,
  input  logic                            gap_en,
  input  logic                            blink_phase,
  output logic [11:0]                     cell_addr,
  input  logic [8+2*COLOR_W:0]            cell_q,
  output logic [$clog2(256*FONT_H)-1:0]   font_addr,
  input  logic [FONT_W-1:0]               font_q,
  output logic [COLOR_W-1:0]              RGB,
  output logic                            HSYNC,
  output logic                            VSYNC,
  output logic                            frame_start
);

  localparam int FA_W = $clog2(256*FONT_H);
  localparam vga_timing_t TIMING = '{16'(RES_H), 16'(H_FP), 16'(H_SYNC), 16'(H_BP),
                                     16'(RES_V), 16'(V_FP), 16'(V_SYNC), 16'(V_BP)};
  localparam logic [15:0] H_LAST  = h_total(TIMING) - 16'd1;
  localparam logic [15:0] V_LAST  = v_total(TIMING) - 16'd1;
  localparam logic [15:0] RES_H_W = 16'(RES_H);
  localparam logic [15:0] RES_V_W = 16'(RES_V);
  localparam logic [15:0] COLS_W  = 16'(COLS);
  localparam logic [15:0] FW      = 16'(FONT_W);
  localparam logic [15:0] FH      = 16'(FONT_H);

  logic [15:0] h_s, v_s;
  logic        hs_raw_s, vs_raw_s;

  vga_timing_gen #(.TIMING(TIMING), .SYNC_POL(SYNC_POL)) u_timing (
    .clk   (clk),
    .reset (reset),
    .h     (h_s),
    .v     (v_s),
    .hsync (hs_raw_s),
    .vsync (vs_raw_s)
  );

  logic [2:0]  sx_r, sy_r, rx_r, ry_r;
  logic        gap_r;
  logic [15:0] cx_r, px_r, xs_r, cy_r, py_r, ys_r;
  logic        at_origin_s, gap_s, en_s, gap_pix_s;
  logic [2:0]  sx_s, sy_s;
  logic [15:0] pw_s, ph_s, cw_s, ch_s;

  // S0 geometry; the origin cycle uses live inputs so the first cell already follows them
  always_comb begin
    at_origin_s = (h_s == 16'd0) && (v_s == 16'd0);
    sx_s        = at_origin_s ? scale_x : sx_r;
    sy_s        = at_origin_s ? scale_y : sy_r;
    gap_s       = at_origin_s ? gap_en  : gap_r;
    pw_s        = FW + {15'd0, gap_s};
    ph_s        = FH + {15'd0, gap_s};
    cw_s        = pw_s * {13'd0, sx_s} + pw_s;
    ch_s        = ph_s * {13'd0, sy_s} + ph_s;
    en_s        = (h_s < RES_H_W) && (v_s < RES_V_W) && (cx_r < COLS_W) &&
                  (xs_r + cw_s <= RES_H_W) && (ys_r + ch_s <= RES_V_W);
    gap_pix_s   = (px_r >= FW) || (py_r >= FH);
  end

  assign cell_addr = 12'(cy_r * COLS_W + cx_r);

  // cell counters describe the pixel currently addressed by h/v
  always_ff @(posedge clk) begin
    if (reset) begin
      {sx_r, sy_r, rx_r, ry_r, gap_r} <= 13'd0;
      {cx_r, px_r, xs_r}              <= 48'd0;
      {cy_r, py_r, ys_r}              <= 48'd0;
    end else begin
      if (at_origin_s) begin
        sx_r  <= scale_x;
        sy_r  <= scale_y;
        gap_r <= gap_en;
      end
      if (h_s == H_LAST) begin
        rx_r <= 3'd0;
        {cx_r, px_r, xs_r} <= 48'd0;
        if (v_s == V_LAST) begin
          ry_r <= 3'd0;
          {cy_r, py_r, ys_r} <= 48'd0;
        end else if (ry_r == sy_s) begin
          ry_r <= 3'd0;
          if (py_r == ph_s - 16'd1) begin
            py_r <= 16'd0;
            cy_r <= cy_r + 16'd1;
            ys_r <= v_s + 16'd1;
          end else begin
            py_r <= py_r + 16'd1;
          end
        end else begin
          ry_r <= ry_r + 3'd1;
        end
      end else if (rx_r == sx_s) begin
        rx_r <= 3'd0;
        if (px_r == pw_s - 16'd1) begin
          px_r <= 16'd0;
          cx_r <= cx_r + 16'd1;
          xs_r <= h_s + 16'd1;
        end else begin
          px_r <= px_r + 16'd1;
        end
      end else begin
        rx_r <= rx_r + 3'd1;
      end
    end
  end

  logic               s1_en_r, s1_gap_r, s1_hs_r, s1_vs_r, s1_fs_r;
  logic [15:0]        s1_frow_r, s1_fcol_r;
  logic               s2_en_r, s2_gap_r, s2_hs_r, s2_vs_r, s2_fs_r, s2_blink_r;
  logic [15:0]        s2_fcol_r;
  logic [COLOR_W-1:0] s2_fg_r, s2_bg_r;
  logic               s3_en_r, s3_gap_r, s3_hs_r, s3_vs_r, s3_fs_r, s3_blink_r;
  logic [15:0]        s3_fcol_r;
  logic [COLOR_W-1:0] s3_fg_r, s3_bg_r;
  logic [FA_W-1:0]    font_addr_r;
  logic [COLOR_W-1:0] rgb_r, pix_s;
  logic               hs_r, vs_r, fs_r;
  logic [FONT_W-1:0]  shifted_s;

  // glyph bit from font_q (MSB leftmost) combined with cell colours
  always_comb begin
    shifted_s = font_q << s3_fcol_r;
    pix_s     = {COLOR_W{1'b0}};
    if (!s3_en_r) begin
      pix_s = {COLOR_W{1'b0}};
    end else if (s3_gap_r) begin
      pix_s = s3_bg_r;
    end else if (shifted_s[FONT_W-1] && !(s3_blink_r && blink_phase)) begin
      pix_s = s3_fg_r;
    end else begin
      pix_s = s3_bg_r;
    end
  end

  // S1..S3 side-band pipeline, font address and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      {s1_en_r, s1_gap_r, s1_fs_r} <= 3'd0;
      {s1_hs_r, s1_vs_r}           <= {~SYNC_POL, ~SYNC_POL};
      {s1_frow_r, s1_fcol_r}       <= 32'd0;
      {s2_en_r, s2_gap_r, s2_fs_r, s2_blink_r} <= 4'd0;
      {s2_hs_r, s2_vs_r}           <= {~SYNC_POL, ~SYNC_POL};
      s2_fcol_r                    <= 16'd0;
      s2_fg_r                      <= {COLOR_W{1'b0}};
      s2_bg_r                      <= {COLOR_W{1'b0}};
      {s3_en_r, s3_gap_r, s3_fs_r, s3_blink_r} <= 4'd0;
      {s3_hs_r, s3_vs_r}           <= {~SYNC_POL, ~SYNC_POL};
      s3_fcol_r                    <= 16'd0;
      s3_fg_r                      <= {COLOR_W{1'b0}};
      s3_bg_r                      <= {COLOR_W{1'b0}};
      font_addr_r                  <= {FA_W{1'b0}};
      rgb_r                        <= {COLOR_W{1'b0}};
      {hs_r, vs_r}                 <= {~SYNC_POL, ~SYNC_POL};
      fs_r                         <= 1'b0;
    end else begin
      s1_en_r     <= en_s;
      s1_gap_r    <= gap_pix_s;
      s1_fs_r     <= at_origin_s;
      s1_hs_r     <= hs_raw_s;
      s1_vs_r     <= vs_raw_s;
      s1_frow_r   <= py_r;
      s1_fcol_r   <= px_r;
      s2_en_r     <= s1_en_r;
      s2_gap_r    <= s1_gap_r;
      s2_fs_r     <= s1_fs_r;
      s2_hs_r     <= s1_hs_r;
      s2_vs_r     <= s1_vs_r;
      s2_fcol_r   <= s1_fcol_r;
      s2_blink_r  <= cell_q[8+2*COLOR_W];
      s2_bg_r     <= cell_q[8+2*COLOR_W-1 -: COLOR_W];
      s2_fg_r     <= cell_q[8+COLOR_W-1 -: COLOR_W];
      font_addr_r <= FA_W'(cell_q[7:0]) * FA_W'(FONT_H) + FA_W'(s1_frow_r);
      s3_en_r     <= s2_en_r;
      s3_gap_r    <= s2_gap_r;
      s3_fs_r     <= s2_fs_r;
      s3_hs_r     <= s2_hs_r;
      s3_vs_r     <= s2_vs_r;
      s3_fcol_r   <= s2_fcol_r;
      s3_blink_r  <= s2_blink_r;
      s3_bg_r     <= s2_bg_r;
      s3_fg_r     <= s2_fg_r;
      rgb_r       <= pix_s;
      hs_r        <= s3_hs_r;
      vs_r        <= s3_vs_r;
      fs_r        <= s3_fs_r;
    end
  end

  assign font_addr   = font_addr_r;
  assign RGB         = rgb_r;
  assign HSYNC       = hs_r;
  assign VSYNC       = vs_r;
  assign frame_start = fs_r;

endmodule

// File: tb/tb_vga_text_layer.sv
// Directed bench for vga_text_layer on a reduced 64x24 raster.
module tb_vga_text_layer;
  import vga_pkg::*;

  localparam int HT    = 64;
  localparam int VT    = 24;
  localparam int FRAME = HT * VT;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [2:0]  scale_x = 3'd0, scale_y = 3'd0;
  logic        gap_en = 1'b0, blink_phase = 1'b0;
  logic [11:0] cell_addr;
  logic [14:0] cell_q;
  logic [10:0] font_addr;
  logic [7:0]  font_q;
  logic [2:0]  RGB;
  logic        HSYNC, VSYNC, frame_start;

  vga_text_layer #(
    .RES_H(48), .RES_V(16), .H_FP(4), .H_SYNC(8), .H_BP(4),
    .V_FP(2), .V_SYNC(2), .V_BP(4), .FONT_W(8), .FONT_H(8),
    .COLOR_W(3), .SYNC_POL(1'b0), .COLS(5)
  ) dut (
    .clk(clk), .reset(reset), .scale_x(scale_x), .scale_y(scale_y),
    .gap_en(gap_en), .blink_phase(blink_phase), .cell_addr(cell_addr),
    .cell_q(cell_q), .font_addr(font_addr), .font_q(font_q), .RGB(RGB),
    .HSYNC(HSYNC), .VSYNC(VSYNC), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  vga_cell_t  cell_mem [4096];
  logic [7:0] font_mem [2048];

  always @(posedge clk) begin
    cell_q <= cell_mem[cell_addr];
    font_q <= font_mem[font_addr];
  end

  int checks = 0;
  int failures = 0;
  int pos = 0;
  int n;
  int exp_row0[8] = '{6, 1, 1, 1, 1, 1, 1, 6};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_fs(output int cnt);
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (frame_start !== 1'b1 && cnt < 2 * FRAME);
  endtask

  task automatic sync_frame();
    int c;
    wait_fs(c);
    chk("frame_period", pos + c, FRAME);
    pos = 0;
  endtask

  task automatic adv_to(input int hh, input int vv);
    while (pos < vv * HT + hh) begin
      @(negedge clk);
      pos++;
    end
  endtask

  task automatic px(input string tag, input int hh, input int vv, input int exp);
    adv_to(hh, vv);
    chk(tag, RGB, exp);
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) cell_mem[i] = '{1'b0, 3'd0, 3'd7, 8'h00};
    for (int i = 0; i < 2048; i++) font_mem[i] = 8'h00;
    cell_mem[0] = '{1'b0, 3'd1, 3'd6, 8'h41};
    cell_mem[1] = '{1'b1, 3'd2, 3'd5, 8'h41};
    cell_mem[2] = '{1'b0, 3'd5, 3'd1, 8'h42};
    cell_mem[4] = '{1'b0, 3'd3, 3'd7, 8'h41};
    cell_mem[5] = '{1'b0, 3'd4, 3'd2, 8'h42};
    font_mem[520] = 8'h81;
    font_mem[521] = 8'hFF;
    for (int r = 3; r < 8; r++) font_mem[520 + r] = 8'h18;
    for (int r = 0; r < 8; r++) font_mem[528 + r] = 8'hF0;

    repeat (3) @(negedge clk);
    chk("reset_rgb", RGB, 0);
    chk("reset_hsync", HSYNC, 1);
    chk("reset_vsync", VSYNC, 1);
    chk("reset_fs", frame_start, 0);
    chk("reset_cell_addr", cell_addr, 0);
    chk("reset_font_addr", font_addr, 0);
    reset = 1'b0;
    wait_fs(n);
    chk("first_fs_latency", n, 4);
    pos = 0;

    // frame: scale 1x, no gap, blink_phase 0
    for (int i = 0; i < 8; i++) px("cell0_row0", i, 0, exp_row0[i]);
    chk("fs_one_cycle", frame_start, 0);
    px("blink_off_fg", 8, 0, 5);
    px("blink_off_bg", 9, 0, 2);
    px("col4_fg", 32, 0, 7);
    px("col4_bg", 33, 0, 3);
    px("col_ge_cols", 40, 0, 0);
    px("hblank", 48, 0, 0);
    adv_to(51, 0); chk("hsync_pre", HSYNC, 1);
    adv_to(52, 0); chk("hsync_start", HSYNC, 0);
    adv_to(59, 0); chk("hsync_end", HSYNC, 0);
    adv_to(60, 0); chk("hsync_post", HSYNC, 1);
    px("row1_ff", 3, 1, 6);
    px("cellrow1_fg", 0, 8, 2);
    px("cellrow1_bg", 4, 8, 4);
    px("vblank", 0, 16, 0);
    adv_to(0, 17); chk("vsync_pre", VSYNC, 1);
    adv_to(0, 18); chk("vsync_start", VSYNC, 0);
    adv_to(63, 19); chk("vsync_end", VSYNC, 0);
    adv_to(0, 20); chk("vsync_post", VSYNC, 1);
    sync_frame();

    // frame: blink_phase 1 hides blinking glyphs only
    blink_phase = 1'b1;
    px("blink_on_msb", 8, 0, 2);
    px("blink_on_lsb", 15, 0, 2);
    px("noblink_fg", 16, 0, 1);
    blink_phase = 1'b0;
    scale_x = 3'd1;
    gap_en  = 1'b1;
    sync_frame();

    // frame: scale_x 2, gap on
    px("sx2_p0b", 1, 0, 6);
    px("sx2_p1a", 2, 0, 1);
    px("sx2_p7b", 15, 0, 6);
    px("gap_col_a", 16, 0, 1);
    px("gap_col_b", 17, 0, 1);
    px("sx2_cell1", 18, 0, 5);
    px("partial_x_a", 36, 0, 0);
    px("partial_x_b", 40, 0, 0);
    adv_to(0, 3);
    scale_x = 3'd0;
    px("midframe_old", 16, 4, 1);
    px("gap_line", 0, 8, 1);
    px("partial_y", 0, 9, 0);
    sync_frame();

    // frame: new scale_x 1x with gap on
    px("new_gap_col", 8, 0, 1);
    px("new_cell1_p0", 9, 0, 5);
    px("new_cell1_p7", 16, 0, 5);
    gap_en = 1'b0;
    px("pre_reset_pix", 4, 3, 6);
    reset = 1'b1;
    @(negedge clk);
    chk("mid_reset_rgb", RGB, 0);
    chk("mid_reset_hsync", HSYNC, 1);
    chk("mid_reset_vsync", VSYNC, 1);
    chk("mid_reset_fs", frame_start, 0);
    chk("mid_reset_cell_addr", cell_addr, 0);
    chk("mid_reset_font_addr", font_addr, 0);
    reset = 1'b0;
    wait_fs(n);
    chk("release_fs_latency", n, 4);
    pos = 0;
    chk("post_reset_px0", RGB, 6);
    px("post_reset_px7", 7, 0, 6);
    px("post_reset_nogap", 8, 0, 5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
